// File: rtl/cajero_param.sv
// rtl/cajero_param.sv - ATM controller: PIN entry with lockout, deposit/withdrawal on a registered balance
// Strobes are rising-edge qualified; result pulses are registered and appear the cycle after PROCESAR.
module cajero_param #(
    parameter int PIN_DIGITS    = 4,
    parameter int MONTO_W       = 32,
    parameter int BALANCE_W     = 40,
    parameter int MAX_INTENTOS  = 3,
    parameter int COMISION      = 500,
    parameter int SALDO_INICIAL = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    tipo_de_tarjeta,
    input  logic [4*PIN_DIGITS-1:0] pin,
    input  logic [3:0]              digito,
    input  logic                    digito_stb,
    input  logic                    tipo_trans,
    input  logic [MONTO_W-1:0]      monto,
    input  logic                    monto_stb,
    output logic                    balance_actualizado,
    output logic                    entregar_dinero,
    output logic                    fondos_insuficientes,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic [BALANCE_W-1:0]    saldo
);

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        INGRESO_PIN,
        VERIFICAR,
        ESPERA_MONTO,
        PROCESAR,
        FIN,
        BLOQUEO
    } estado_t;

    localparam int CW = $clog2(PIN_DIGITS + 1);
    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam logic [CW-1:0]        ULTIMO    = CW'(PIN_DIGITS - 1);
    localparam logic [IW-1:0]        INT_MAX   = IW'(MAX_INTENTOS);
    localparam logic [IW-1:0]        INT_AVISO = IW'(MAX_INTENTOS - 1);
    localparam logic [BALANCE_W:0]   COM_EXT   = (BALANCE_W + 1)'(COMISION);
    localparam logic [BALANCE_W-1:0] SALDO_INI = BALANCE_W'(SALDO_INICIAL);

    estado_t                 estado_q, estado_d;
    logic [CW-1:0]           cuenta_q, cuenta_d;
    logic [4*PIN_DIGITS-1:0] digitos_q, digitos_d;
    logic                    digito_malo_q, digito_malo_d;
    logic [IW-1:0]           intentos_q, intentos_d;
    logic                    advertencia_q, advertencia_d;
    logic                    bloqueo_q, bloqueo_d;
    logic [BALANCE_W-1:0]    saldo_q, saldo_d;
    logic [MONTO_W-1:0]      monto_q, monto_d;
    logic                    tipo_trans_q, tipo_trans_d;
    logic                    digito_prev_q, digito_prev_d;
    logic                    monto_prev_q, monto_prev_d;
    logic                    bal_q, bal_d;
    logic                    entregar_q, entregar_d;
    logic                    fondos_q, fondos_d;
    logic                    pin_mal_q, pin_mal_d;

    logic                    digito_acept;
    logic                    monto_acept;
    logic [IW-1:0]           intentos_inc;
    logic [BALANCE_W:0]      monto_ext;
    logic [BALANCE_W:0]      suma;
    logic [BALANCE_W:0]      costo;

    assign digito_acept = digito_stb & ~digito_prev_q;
    assign monto_acept  = monto_stb & ~monto_prev_q;
    assign intentos_inc = intentos_q + IW'(1);
    // One extra bit so a deposit overflow and a withdrawal cost are both exact.
    assign monto_ext    = {{(BALANCE_W + 1 - MONTO_W){1'b0}}, monto_q};
    assign suma         = {1'b0, saldo_q} + monto_ext;
    assign costo        = monto_ext + (tipo_de_tarjeta ? COM_EXT : '0);

    always_comb begin
        estado_d      = estado_q;
        cuenta_d      = cuenta_q;
        digitos_d     = digitos_q;
        digito_malo_d = digito_malo_q;
        intentos_d    = intentos_q;
        advertencia_d = advertencia_q;
        bloqueo_d     = bloqueo_q;
        saldo_d       = saldo_q;
        monto_d       = monto_q;
        tipo_trans_d  = tipo_trans_q;
        digito_prev_d = digito_stb;
        monto_prev_d  = monto_stb;
        bal_d         = 1'b0;
        entregar_d    = 1'b0;
        fondos_d      = 1'b0;
        pin_mal_d     = 1'b0;

        case (estado_q)
            ESPERA_TARJETA: begin
                if (tarjeta_recibida) begin
                    estado_d      = INGRESO_PIN;
                    cuenta_d      = '0;
                    digito_malo_d = 1'b0;
                end
            end
            INGRESO_PIN: begin
                if (!tarjeta_recibida) begin
                    estado_d = ESPERA_TARJETA;
                    cuenta_d = '0;
                end else if (digito_acept) begin
                    // First digit lands in the most-significant nibble.
                    for (int i = 0; i < PIN_DIGITS; i++) begin
                        if (cuenta_q == CW'(i)) begin
                            digitos_d[4*(PIN_DIGITS-1-i) +: 4] = digito;
                        end
                    end
                    if (digito > 4'd9) begin
                        digito_malo_d = 1'b1;
                    end
                    if (cuenta_q == ULTIMO) begin
                        estado_d = VERIFICAR;
                        cuenta_d = '0;
                    end else begin
                        cuenta_d = cuenta_q + CW'(1);
                    end
                end
            end
            VERIFICAR: begin
                if (!tarjeta_recibida) begin
                    estado_d = ESPERA_TARJETA;
                    cuenta_d = '0;
                end else if (digitos_q == pin && !digito_malo_q) begin
                    intentos_d    = '0;
                    advertencia_d = 1'b0;
                    estado_d      = ESPERA_MONTO;
                end else begin
                    pin_mal_d  = 1'b1;
                    intentos_d = intentos_inc;
                    if (intentos_inc == INT_AVISO) begin
                        advertencia_d = 1'b1;
                    end
                    if (intentos_inc == INT_MAX) begin
                        estado_d  = BLOQUEO;
                        bloqueo_d = 1'b1;
                    end else begin
                        estado_d      = INGRESO_PIN;
                        cuenta_d      = '0;
                        digito_malo_d = 1'b0;
                    end
                end
            end
            ESPERA_MONTO: begin
                if (!tarjeta_recibida) begin
                    estado_d = ESPERA_TARJETA;
                    cuenta_d = '0;
                end else if (monto_acept) begin
                    monto_d      = monto;
                    tipo_trans_d = tipo_trans;
                    estado_d     = PROCESAR;
                end
            end
            PROCESAR: begin
                if (!tipo_trans_q) begin
                    saldo_d = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                    bal_d   = 1'b1;
                end else if (costo <= {1'b0, saldo_q}) begin
                    saldo_d    = saldo_q - costo[BALANCE_W-1:0];
                    entregar_d = 1'b1;
                    bal_d      = 1'b1;
                end else begin
                    fondos_d = 1'b1;
                end
                estado_d = FIN;
            end
            FIN: begin
                if (!tarjeta_recibida) begin
                    estado_d = ESPERA_TARJETA;
                end
            end
            BLOQUEO: begin
                bloqueo_d = 1'b1;
            end
            default: begin
                estado_d = ESPERA_TARJETA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q      <= ESPERA_TARJETA;
            cuenta_q      <= '0;
            digitos_q     <= '0;
            digito_malo_q <= 1'b0;
            intentos_q    <= '0;
            advertencia_q <= 1'b0;
            bloqueo_q     <= 1'b0;
            saldo_q       <= SALDO_INI;
            monto_q       <= '0;
            tipo_trans_q  <= 1'b0;
            digito_prev_q <= 1'b0;
            monto_prev_q  <= 1'b0;
            bal_q         <= 1'b0;
            entregar_q    <= 1'b0;
            fondos_q      <= 1'b0;
            pin_mal_q     <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            cuenta_q      <= cuenta_d;
            digitos_q     <= digitos_d;
            digito_malo_q <= digito_malo_d;
            intentos_q    <= intentos_d;
            advertencia_q <= advertencia_d;
            bloqueo_q     <= bloqueo_d;
            saldo_q       <= saldo_d;
            monto_q       <= monto_d;
            tipo_trans_q  <= tipo_trans_d;
            digito_prev_q <= digito_prev_d;
            monto_prev_q  <= monto_prev_d;
            bal_q         <= bal_d;
            entregar_q    <= entregar_d;
            fondos_q      <= fondos_d;
            pin_mal_q     <= pin_mal_d;
        end
    end

    assign balance_actualizado  = bal_q;
    assign entregar_dinero      = entregar_q;
    assign fondos_insuficientes = fondos_q;
    assign pin_incorrecto       = pin_mal_q;
    assign advertencia          = advertencia_q;
    assign bloqueo              = bloqueo_q;
    assign saldo                = saldo_q;

endmodule
